rst_seq_ctl: RTL
================

RST_SEQ_CTL -- requirements
Module: rst_seq_ctl

Interface
REQ-001 SHALL have parameter MIN_ASSERT_CYC, default 8: minimum cycles all reset requests stay asserted after any (re)entry to ASSERT.
REQ-002 SHALL have parameter LOCK_STABLE_CYC, default 64: consecutive clock_locked=1 cycles required before release starts.
REQ-003 SHALL have parameter STEP_CYC, default 16: cycles between successive domain releases.
REQ-004 SHALL have port clk_rx, input, 1: the single clock; all logic on rising edge.
REQ-005 SHALL have port rst_clk_rx, input, 1: reset, synchronous, active-high.
REQ-006 SHALL have port clock_locked, input, 1: clock-generator lock, already synchronized to clk_rx.
REQ-007 SHALL have port restart_req, input, 1: level request for a full reset re-sequence.
REQ-008 SHALL have port restart_ack, output, 1: one-cycle pulse accepting restart_req.
REQ-009 SHALL have ports rst_req_rx, rst_req_tx, rst_req_samp, output, 1 each: active-high reset requests feeding the per-domain reset bridges.
REQ-010 SHALL have port seq_done, output, 1: high only in RUN.
REQ-011 SHALL have port lock_loss_cnt, output, 8: saturating count of lock-loss events.

Function
REQ-012 SHALL implement states ASSERT, WAIT_LOCK, REL_RX, REL_TX, REL_SAMP, RUN with one shared cycle counter, width clog2(max parameter)+1.
REQ-013 ASSERT: all three rst_req high; after MIN_ASSERT_CYC cycles in state -> WAIT_LOCK; clock_locked ignored.
REQ-014 WAIT_LOCK: counter increments while clock_locked=1, clears to 0 on any clock_locked=0; reaching LOCK_STABLE_CYC -> REL_RX.
REQ-015 REL_RX: rst_req_rx low from the first cycle in state (registered output, i.e. one cycle after the transition edge); after STEP_CYC cycles -> REL_TX.
REQ-016 REL_TX: rst_req_tx additionally low; after STEP_CYC cycles -> REL_SAMP.
REQ-017 REL_SAMP: rst_req_samp additionally low; after STEP_CYC cycles -> RUN; seq_done high from first RUN cycle.
REQ-018 Release order SHALL always be rx, tx, samp; reassertion SHALL be simultaneous for all three.
REQ-019 Lock loss: clock_locked=0 sampled in REL_RX, REL_TX, REL_SAMP or RUN -> ASSERT next cycle; all rst_req high and seq_done low from that cycle; lock_loss_cnt +1, saturating at 255.
REQ-020 restart_req=1 in RUN (and clock_locked=1) -> restart_ack pulses in the same cycle the state moves to ASSERT; restart_req in other states is not acknowledged and remains pending.
REQ-021 Simultaneous lock loss and restart_req in RUN: lock loss wins, no restart_ack, counter increments; pending restart_req is acknowledged on next RUN entry.
REQ-022 Counter SHALL clear on every state transition.
REQ-023 Parameters SHALL each be >=1; values of 1 give exactly one cycle in the corresponding state.

Reset
REQ-024 On rst_clk_rx=1: state ASSERT, counter 0, rst_req_* = 1, seq_done 0, restart_ack 0, lock_loss_cnt 0.
REQ-025 Reset asserted mid-sequence SHALL behave identically to reset from power-up; lock_loss_cnt SHALL clear only on rst_clk_rx.

Structure
REQ-026 State enumeration and default parameter constants SHALL live in shared package rst_seq_pkg.
REQ-027 No sub-module; single FSM plus one counter and the lock-loss counter.

Verification
REQ-028 Reset released, clock_locked=1 constant -> rst_req_rx falls 8+64 cycles after ASSERT entry, tx 16 later, samp 16 later, seq_done high 16 after samp.
REQ-029 clock_locked drops for 1 cycle at 40 cycles into WAIT_LOCK -> stable count restarts; release delayed by 41 cycles; lock_loss_cnt stays 0.
REQ-030 clock_locked drops in RUN -> all rst_req high next cycle, seq_done low, lock_loss_cnt=1; full re-sequence follows.
REQ-031 restart_req held high from WAIT_LOCK -> no ack until RUN; then one-cycle restart_ack and re-sequence.
REQ-032 restart_req and clock_locked=0 same RUN cycle -> no ack, lock_loss_cnt+1; ack on next RUN entry.
REQ-033 300 lock-loss events -> lock_loss_cnt saturates at 255; rst_clk_rx mid-REL_TX -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/rst_seq_pkg.sv
// Shared definitions for the reset sequencer: state encoding, default timing
// constants and small combinational helpers.
package rst_seq_pkg;

    typedef enum logic [2:0] {
        ASSERT    = 3'd0,
        WAIT_LOCK = 3'd1,
        REL_RX    = 3'd2,
        REL_TX    = 3'd3,
        REL_SAMP  = 3'd4,
        RUN       = 3'd5
    } seq_state_e;

    localparam int unsigned DEF_MIN_ASSERT_CYC  = 32'd8;
    localparam int unsigned DEF_LOCK_STABLE_CYC = 32'd64;
    localparam int unsigned DEF_STEP_CYC        = 32'd16;
    localparam logic [7:0]  LOCK_LOSS_MAX       = 8'd255;

    // Reset request pattern {samp, tx, rx} held in each state; release is rx, tx, samp.
    function automatic logic [2:0] rst_mask(input seq_state_e st);
        logic [2:0] m;
        case (st)
            ASSERT, WAIT_LOCK: m = 3'b111;
            REL_RX:            m = 3'b110;
            REL_TX:            m = 3'b100;
            REL_SAMP, RUN:     m = 3'b000;
            default:           m = 3'b111;
        endcase
        return m;
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        logic [7:0] r;
        if (v == LOCK_LOSS_MAX) begin
            r = v;
        end else begin
            r = v + 8'd1;
        end
        return r;
    endfunction

    function automatic int unsigned max3(input int unsigned a,
                                         input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) begin
            m = b;
        end else begin
            m = m;
        end
        if (c > m) begin
            m = c;
        end else begin
            m = m;
        end
        return m;
    endfunction

endpackage

// File: rtl/rst_seq_ctl.sv
// Reset sequencer: holds all domain resets, waits for a stable clock lock,
// then releases rx, tx and samp in order; lock loss or restart re-sequences.
module rst_seq_ctl
    import rst_seq_pkg::*;
#(
    parameter int unsigned MIN_ASSERT_CYC  = DEF_MIN_ASSERT_CYC,
    parameter int unsigned LOCK_STABLE_CYC = DEF_LOCK_STABLE_CYC,
    parameter int unsigned STEP_CYC        = DEF_STEP_CYC
) (
    input  logic       clk_rx,
    input  logic       rst_clk_rx,
    input  logic       clock_locked,
    input  logic       restart_req,
    output logic       restart_ack,
    output logic       rst_req_rx,
    output logic       rst_req_tx,
    output logic       rst_req_samp,
    output logic       seq_done,
    output logic [7:0] lock_loss_cnt
);

    localparam int unsigned MAX_CYC = max3(MIN_ASSERT_CYC, LOCK_STABLE_CYC, STEP_CYC);
    localparam int unsigned CNT_W   = $clog2(MAX_CYC) + 1;

    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] MIN_LAST  = CNT_W'(MIN_ASSERT_CYC - 32'd1);
    localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_STABLE_CYC - 32'd1);
    localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(STEP_CYC - 32'd1);

    seq_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_step_s;
    logic [2:0]       rst_req_q, rst_req_d;
    logic             seq_done_q, seq_done_d;
    logic             restart_ack_q, restart_ack_d;
    logic [7:0]       loss_cnt_q, loss_cnt_d;
    logic             lock_lost_s;

    // Next-state, counter and next-output computation
    always_comb begin
        state_d       = state_q;
        cnt_step_s    = cnt_q + CNT_ONE;
        restart_ack_d = 1'b0;
        lock_lost_s   = 1'b0;

        case (state_q)
            ASSERT: begin
                if (cnt_q == MIN_LAST) begin
                    state_d = WAIT_LOCK;
                end else begin
                    state_d = ASSERT;
                end
            end
            WAIT_LOCK: begin
                // Any unlocked cycle restarts the stability window.
                if (!clock_locked) begin
                    cnt_step_s = CNT_ZERO;
                end else if (cnt_q == LOCK_LAST) begin
                    state_d = REL_RX;
                end else begin
                    state_d = WAIT_LOCK;
                end
            end
            REL_RX: begin
                if (!clock_locked) begin
                    lock_lost_s = 1'b1;
                end else if (cnt_q == STEP_LAST) begin
                    state_d = REL_TX;
                end else begin
                    state_d = REL_RX;
                end
            end
            REL_TX: begin
                if (!clock_locked) begin
                    lock_lost_s = 1'b1;
                end else if (cnt_q == STEP_LAST) begin
                    state_d = REL_SAMP;
                end else begin
                    state_d = REL_TX;
                end
            end
            REL_SAMP: begin
                if (!clock_locked) begin
                    lock_lost_s = 1'b1;
                end else if (cnt_q == STEP_LAST) begin
                    state_d = RUN;
                end else begin
                    state_d = REL_SAMP;
                end
            end
            RUN: begin
                // Lock loss outranks a restart request in the same cycle.
                if (!clock_locked) begin
                    lock_lost_s = 1'b1;
                end else if (restart_req) begin
                    state_d       = ASSERT;
                    restart_ack_d = 1'b1;
                end else begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = ASSERT;
            end
        endcase

        if (lock_lost_s) begin
            state_d    = ASSERT;
            loss_cnt_d = sat_inc8(loss_cnt_q);
        end else begin
            loss_cnt_d = loss_cnt_q;
        end

        if (state_d != state_q) begin
            cnt_d = CNT_ZERO;
        end else begin
            cnt_d = cnt_step_s;
        end

        rst_req_d  = rst_mask(state_d);
        seq_done_d = (state_d == RUN);
    end

    // State, counter and registered outputs with synchronous reset
    always_ff @(posedge clk_rx) begin
        if (rst_clk_rx) begin
            state_q       <= ASSERT;
            cnt_q         <= CNT_ZERO;
            rst_req_q     <= 3'b111;
            seq_done_q    <= 1'b0;
            restart_ack_q <= 1'b0;
            loss_cnt_q    <= 8'd0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            rst_req_q     <= rst_req_d;
            seq_done_q    <= seq_done_d;
            restart_ack_q <= restart_ack_d;
            loss_cnt_q    <= loss_cnt_d;
        end
    end

    assign rst_req_rx    = rst_req_q[0];
    assign rst_req_tx    = rst_req_q[1];
    assign rst_req_samp  = rst_req_q[2];
    assign seq_done      = seq_done_q;
    assign restart_ack   = restart_ack_q;
    assign lock_loss_cnt = loss_cnt_q;

endmodule
